fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, 10, program counter and instruction-memory address width in bits.
REQ-002 Parameter CNT_W, 16, width of the executed-instruction counter.
REQ-003 Port clock input 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset input 1: asynchronous, active-high reset.
REQ-005 Port start input 1: single-cycle pulse to begin execution.
REQ-006 Port start_addr input PC_W: PC loaded on an accepted start.
REQ-007 Port imem_addr output PC_W: instruction-memory read address; always equals pc.
REQ-008 Port imem_data input 9: instruction-memory read data, combinational from imem_addr.
REQ-009 Port instruction output 9: instruction presented to the decoder.
REQ-010 Port instr_valid output 1: the instruction output is live this cycle.
REQ-011 Port branch input 1: decoder branch flag for the current instruction.
REQ-012 Port branch_taken input 1: ALU comparison result for beq/blt.
REQ-013 Port jmp_ctrl input 1: decoder jump flag.
REQ-014 Port done_ctrl input 1: decoder halt flag.
REQ-015 Port target_addr input PC_W: branch or jump destination for the current instruction.
REQ-016 Port halted output 1: the HALTED state is active.
REQ-017 Port instr_count output CNT_W: number of instructions retired since the last start.

Function
REQ-018 The FSM shall have three states: IDLE, RUN and HALTED.
REQ-019 IDLE shall move to RUN on start; pc shall load start_addr and instr_count shall clear to 0.
REQ-020 HALTED shall move to RUN on start, with the same pc load and counter clear as from IDLE.
REQ-021 start shall be ignored while the FSM is in RUN.
REQ-022 In RUN, instruction shall equal imem_data and instr_valid shall be 1, with zero added latency.
REQ-023 In IDLE or HALTED, instruction shall be 9'b0111_00_010 (the halt encoding) and instr_valid shall be 0.
REQ-024 In RUN, the next pc shall be selected by this priority:
- done_ctrl: hold pc and go to HALTED.
- jmp_ctrl: load target_addr.
- branch and branch_taken: load target_addr.
- otherwise: pc+1, wrapping modulo 2^PC_W (all ones wraps to 0).
REQ-025 branch with branch_taken=0 shall select pc+1.
REQ-026 branch_taken shall be ignored whenever branch=0.
REQ-027 If done_ctrl is asserted together with jmp_ctrl or branch, done_ctrl shall win.
REQ-028 instr_count shall increment by 1 on every RUN cycle, including the halt cycle.
REQ-029 instr_count shall saturate at all ones.
REQ-030 In IDLE and HALTED, pc and instr_count shall hold their values.
REQ-031 halted shall be a registered flag, equal to 1 exactly while the state is HALTED.
REQ-032 The decoder inputs (branch, jmp_ctrl, done_ctrl, target_addr) shall be sampled on the same edge that retires the current instruction; no pipelining.

Reset
REQ-033 Asserting reset shall asynchronously force the following, regardless of the current state or any in-flight instruction:
- state = IDLE
- pc = 0
- instr_count = 0
- halted = 0
- instr_valid = 0
- instruction = halt encoding
REQ-034 The first rising edge after reset deassertion shall honour start.

Structure
REQ-035 A shared package shall hold:
- the 4-bit opcodes and 3-bit special sub-opcodes;
- HALT_INSTR = 9'b011100010;
- the FSM state encoding (2 bits).
REQ-036 The next-PC priority mux and wrap logic shall be a sub-module named pc_next_logic; all other logic shall be flat.

Verification
REQ-037 Reset, then start with start_addr=5 and sequential instructions for 3 cycles:
- imem_addr shall step 5, 6, 7, 8;
- instr_valid shall be 1 from the first RUN cycle;
- instr_count shall reach 3.
REQ-038 In RUN at pc=20, drive branch=1:
- with branch_taken=1 and target_addr=3, the next pc shall be 3;
- with branch_taken=0, the next pc shall be 21.
REQ-039 Drive jmp_ctrl=1 with target_addr=100 at pc=7:
- the next pc shall be 100;
- simultaneous done_ctrl=1 shall instead hold pc=7 and set halted=1.
REQ-040 Run with pc=1023 and sequential flow: the next pc shall be 0.
REQ-041 After halting with instr_count=9:
- start with start_addr=0 shall give instr_count=0, pc=0 and halted=0;
- start in RUN shall leave pc unchanged.
REQ-042 Assert reset asynchronously mid-RUN at pc=50: pc=0, state=IDLE and instr_valid=0 shall all hold before the next clock edge.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the fetch unit: opcodes, special sub-opcodes,
// the halt instruction and the fetch FSM state codes.
package fetch_unit_pkg;

    localparam int INSTR_W = 9;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_LD   = 4'b0100;
    localparam logic [3:0] OP_ST   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_SPEC = 4'b0111;
    localparam logic [3:0] OP_BLT  = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_LI   = 4'b1010;

    localparam logic [2:0] SUB_NOP  = 3'b000;
    localparam logic [2:0] SUB_INC  = 3'b001;
    localparam logic [2:0] SUB_HALT = 3'b010;
    localparam logic [2:0] SUB_NOT  = 3'b011;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'b011100010;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    function automatic logic [INSTR_W-1:0] mk_special(input logic [2:0] sub);
        return {OP_SPEC, 2'b00, sub};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next_logic.sv
// Next-PC selection: halt hold, jump, taken branch, else wrapping increment.
module pc_next_logic #(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] pc,
    input  logic            done_ctrl,
    input  logic            jmp_ctrl,
    input  logic            branch,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] target_addr,
    output logic [PC_W-1:0] pc_next,
    output logic            halt_req
);

    logic [PC_W-1:0] pc_inc;

    // Natural overflow of the PC_W-bit add gives the modulo wrap.
    assign pc_inc   = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign halt_req = done_ctrl;

    always_comb begin
        pc_next = pc_inc;
        priority case (1'b1)
            done_ctrl:              pc_next = pc;
            jmp_ctrl:               pc_next = target_addr;
            (branch & branch_taken): pc_next = target_addr;
            default:                pc_next = pc_inc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: holds the PC, presents instructions while
// running, and counts retired instructions between starts and halts.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    start_addr,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    input  logic               branch,
    input  logic               branch_taken,
    input  logic               jmp_ctrl,
    input  logic               done_ctrl,
    input  logic [PC_W-1:0]    target_addr,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic [PC_W-1:0]  pc_nxt;
    logic             halt_req;
    logic             running;

    pc_next_logic #(.PC_W(PC_W)) u_pc_next (
        .pc           (pc_q),
        .done_ctrl    (done_ctrl),
        .jmp_ctrl     (jmp_ctrl),
        .branch       (branch),
        .branch_taken (branch_taken),
        .target_addr  (target_addr),
        .pc_next      (pc_nxt),
        .halt_req     (halt_req)
    );

    assign running = (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = start_addr;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                // Every RUN edge retires one instruction, the halt included.
                pc_d  = pc_nxt;
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (halt_req) begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instruction = running ? imem_data : HALT_INSTR;
    assign instr_valid = running;
    assign halted      = halted_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;
    localparam logic [8:0] HALT = 9'b011100010;

    logic             clock;
    logic             reset;
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic [PC_W-1:0]  imem_addr;
    logic [8:0]       imem_data;
    logic [8:0]       instruction;
    logic             instr_valid;
    logic             branch;
    logic             branch_taken;
    logic             jmp_ctrl;
    logic             done_ctrl;
    logic [PC_W-1:0]  target_addr;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .branch       (branch),
        .branch_taken (branch_taken),
        .jmp_ctrl     (jmp_ctrl),
        .done_ctrl    (done_ctrl),
        .target_addr  (target_addr),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory model: content is a fixed scramble of the address.
    assign imem_data = imem_addr[8:0] ^ 9'h155;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_state(input string tag, input int pc, input int cnt);
        check({tag, "_pc"}, 32'(imem_addr), 32'(pc));
        check({tag, "_cnt"}, 32'(instr_count), 32'(cnt));
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_instr"}, 32'(instruction), 32'(9'(pc) ^ 9'h155));
        check({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    task automatic clr();
        start = 0; branch = 0; branch_taken = 0;
        jmp_ctrl = 0; done_ctrl = 0; target_addr = '0; start_addr = '0;
    endtask

    task automatic jump_to(input int a);
        jmp_ctrl = 1; target_addr = PC_W'(a);
        tick();
        clr();
    endtask

    initial begin
        reset = 1;
        clr();
        #3;
        check("rst_pc", 32'(imem_addr), 0);
        check("rst_cnt", 32'(instr_count), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr", 32'(instruction), 32'(HALT));
        check("rst_halted", 32'(halted), 0);
        tick();
        reset = 0;
        tick();
        check("idle_hold_pc", 32'(imem_addr), 0);
        check("idle_valid", 32'(instr_valid), 0);

        // Start at 5, three sequential instructions
        start = 1; start_addr = 10'd5;
        tick();
        clr();
        run_state("seq0", 5, 0);
        tick(); run_state("seq1", 6, 1);
        tick(); run_state("seq2", 7, 2);
        tick(); run_state("seq3", 8, 3);

        // Branches at pc=20
        jump_to(20); run_state("j20a", 20, 4);
        branch = 1; branch_taken = 1; target_addr = 10'd3;
        tick(); clr();
        run_state("br_taken", 3, 5);
        jump_to(20); run_state("j20b", 20, 6);
        branch = 1; branch_taken = 0; target_addr = 10'd3;
        tick(); clr();
        run_state("br_not", 21, 7);
        branch = 0; branch_taken = 1; target_addr = 10'd3;
        tick(); clr();
        run_state("taken_no_br", 22, 8);

        // Jump at pc=7, then jump with done
        jump_to(7); run_state("j7a", 7, 9);
        jump_to(100); run_state("jmp100", 100, 10);
        jump_to(7); run_state("j7b", 7, 11);
        jmp_ctrl = 1; done_ctrl = 1; branch = 1; branch_taken = 1;
        target_addr = 10'd100;
        tick(); clr();
        check("done_pc", 32'(imem_addr), 7);
        check("done_halted", 32'(halted), 1);
        check("done_valid", 32'(instr_valid), 0);
        check("done_instr", 32'(instruction), 32'(HALT));
        check("done_cnt", 32'(instr_count), 12);
        jmp_ctrl = 1; target_addr = 10'd99;
        tick(); clr();
        check("halt_hold_pc", 32'(imem_addr), 7);
        check("halt_hold_cnt", 32'(instr_count), 12);
        check("halt_hold_flag", 32'(halted), 1);

        // Restart from HALTED at 1023, wrap to 0
        start = 1; start_addr = 10'd1023;
        tick(); clr();
        run_state("wrap0", 1023, 0);
        tick(); run_state("wrap1", 0, 1);
        for (int i = 0; i < 7; i++) tick();
        run_state("pre_halt", 7, 8);
        done_ctrl = 1;
        tick(); clr();
        check("h9_cnt", 32'(instr_count), 9);
        check("h9_halted", 32'(halted), 1);
        start = 1; start_addr = 10'd0;
        tick(); clr();
        run_state("restart0", 0, 0);
        start = 1; start_addr = 10'd200;
        tick(); clr();
        run_state("start_in_run", 1, 1);

        // Asynchronous reset mid-RUN at pc=50
        jump_to(50); run_state("j50", 50, 2);
        #2 reset = 1;
        #1;
        check("arst_pc", 32'(imem_addr), 0);
        check("arst_valid", 32'(instr_valid), 0);
        check("arst_instr", 32'(instruction), 32'(HALT));
        check("arst_cnt", 32'(instr_count), 0);
        check("arst_halted", 32'(halted), 0);
        tick();
        reset = 0;
        start = 1; start_addr = 10'd9;
        tick(); clr();
        run_state("post_rst", 9, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
